adder_result_checker: RTL
=========================

# adder_result_checker

Synthesizable response checker for the single-cycle MIPS datapath adder. It is the receiving end of the adder's stimulus path: it consumes operand/result triples `a`, `b`, `y` and recomputes `a + b` modulo 2^WIDTH. It counts passes and failures and captures the first mismatching vector. It can sit beside the adder on an FPGA or in a self-checking bench, and it reports a run summary after a programmed number of vectors.

## Interface
- `WIDTH`, 32: operand/result width.
- `CNT_W`, 16: width of the vector-count and result counters.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a run; sampled in IDLE and DONE only.
- `vec_total`  in  CNT_W  number of vectors in the run; latched on an accepted `start`.
- `in_valid`  in  1  a/b/y triple presented this cycle; honoured in RUN only.
- `a`, `b`  in  WIDTH  adder operands.
- `y`  in  WIDTH  adder result under check.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass_cnt`, `fail_cnt`  out  CNT_W  result counters.
- `err`  out  1  sticky; set by any mismatch in the current run.
- `fail_idx`  out  CNT_W  0-based index of the first failing vector.
- `fail_a`, `fail_b`, `fail_y`  out  WIDTH  the first failing triple.

## Operation
- **States:**
  - IDLE: reset state.
  - RUN.
  - DONE.
- **IDLE/DONE, `start`=1:**
  - Clear `pass_cnt`, `fail_cnt`, `err`, `fail_*` and the internal accept counter `seen`.
  - Latch `vec_total`.
  - Go to RUN if `vec_total`≠0; otherwise go directly to DONE with zero counts.
- **RUN, `in_valid`=1:**
  - Compute expected = `(a + b)` truncated to WIDTH bits; carry-out is discarded, so wrap-around is legal.
  - If `y` == expected, increment `pass_cnt`. Otherwise increment `fail_cnt` and set `err`.
  - On the first mismatch of the run only (`err` was 0), capture `fail_idx`=`seen` and `a`/`b`/`y` into `fail_a`/`fail_b`/`fail_y`. Later mismatches do not overwrite the capture.
  - `seen` increments. When `seen`+1 == latched total, go to DONE on the same edge.
- **RUN, `in_valid`=0:** no change; there is no timeout.
- **`start` in RUN:** ignored. The latched total is unaffected.
- **`in_valid` in IDLE/DONE:** ignored. No counter moves.
- **Counter saturation:** counters saturate at 2^CNT_W−1. `seen` cannot exceed the latched total, so it cannot wrap.
- **DONE:** all outputs hold until the next `start` or reset.
- **Reset:** asserting `reset` at any time, including mid-run, forces:
  - state IDLE;
  - all outputs 0: `busy`, `done`, `err`, both counters, `fail_idx`, `fail_a`, `fail_b`, `fail_y`;
  - `seen` and the latched total also 0.

## Timing
- All outputs are registered and change only on the rising `clk` edge, except on asynchronous reset assertion.
- **Check latency:** one cycle. A triple sampled at edge N is reflected in the counters, `err` and `fail_*` after edge N.
- **Throughput:** one vector per cycle; `in_valid` may be held high back-to-back.
- **Run completion:** `done` rises and `busy` falls on the same edge that accounts for the last vector. Final counts are valid in the first `done` cycle.
- **Start/busy:** a `start` accepted at edge N gives `busy`=1 from edge N (or `done`=1 if `vec_total`=0). A simultaneous `in_valid` on that edge is ignored.
- **Reset release:** release is synchronised by the register behaviour only. The first functional edge is the first rising edge with `reset`=1.

## Test plan
- **Basic pass/fail, `vec_total`=2:**
  - Stimulus: (a=5, b=6, y=11) then (a=6, b=9, y=16), back-to-back.
  - Required: `pass_cnt`=1, `fail_cnt`=1, `err`=1, `fail_idx`=1, `fail_a`=6, `fail_b`=9, `fail_y`=16. `done`=1 on the edge after the second vector.
- **Wrap-around and first-fail capture:**
  - Stimulus: `vec_total`=3. Vectors (0xFFFFFFFF, 1, 0), then (0x80000000, 0x80000000, 1), then (3, 4, 0).
  - Required: pass=1, fail=2. `fail_idx`=1 and `fail_y`=1, i.e. not overwritten by the third vector.
- **Zero-length run and idle gaps:**
  - Stimulus 1: `start` with `vec_total`=0.
  - Required 1: `done`=1 next cycle, counts 0, `busy` never high.
  - Stimulus 2: `vec_total`=2 with `in_valid` gaps of 3 idle cycles between vectors.
  - Required 2: `busy` stays high through the gaps; `done` only after the second vector.
- **Ignored inputs:**
  - `in_valid` pulses in IDLE and DONE leave the counters unchanged.
  - `start` with `vec_total`=5 asserted mid-run (original total 3) does not alter completion; the run ends after 3 vectors.
- **Reset mid-run:**
  - Stimulus: assert `reset` between clock edges after 2 of 4 vectors, one of them failing.
  - Required: all outputs are 0 immediately, without waiting for a clock edge. After release, a new `start` with `vec_total`=1 and (5, 6, 11) gives pass=1, `err`=0.
- **Restart from DONE:**
  - Stimulus: after a run ending with `err`=1, issue `start`.
  - Required: `err`, `fail_*` and the counters clear on the `start` edge; the new run counts from 0.

Source files
------------

// File: rtl/adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_result_checker
// Purpose  : Response checker for the datapath adder. It recomputes a + b
//            modulo 2^WIDTH for each accepted triple, counts passes and
//            failures, captures the first failing vector and reports when a
//            programmed number of vectors has been consumed.
// Revision : 1.0 - initial release
// ============================================================================
module adder_result_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active low
    input  logic             start,
    input  logic [CNT_W-1:0] vec_total,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] fail_idx,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_y
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_ZERO = '0;
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_MAX  = '1;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] fail_cnt_q;
    logic             err_q;
    logic [CNT_W-1:0] fail_idx_q;
    logic [WIDTH-1:0] fail_a_q;
    logic [WIDTH-1:0] fail_b_q;
    logic [WIDTH-1:0] fail_y_q;
    logic [CNT_W-1:0] seen_q;
    logic [CNT_W-1:0] total_q;

    logic [WIDTH-1:0] expected_d;
    logic             match_d;
    logic [CNT_W-1:0] pass_inc_d;
    logic [CNT_W-1:0] fail_inc_d;
    logic [CNT_W-1:0] seen_inc_d;
    logic             last_vec_d;
    logic             accept_d;
    logic             start_ok_d;

    // Expected sum (carry discarded), saturating increments and run control.
    always_comb begin
        expected_d = a + b;
        match_d    = (y == expected_d);
        pass_inc_d = (pass_cnt_q == C_MAX) ? pass_cnt_q : pass_cnt_q + C_ONE;
        fail_inc_d = (fail_cnt_q == C_MAX) ? fail_cnt_q : fail_cnt_q + C_ONE;
        // seen never exceeds the latched total, so this increment cannot wrap
        // while it is being used.
        seen_inc_d = seen_q + C_ONE;
        last_vec_d = (seen_inc_d == total_q);
        accept_d   = (state_q == S_RUN) && in_valid;
        start_ok_d = (state_q != S_RUN) && start;
    end

    // Checker FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_cnt_q <= C_ZERO;
            fail_cnt_q <= C_ZERO;
            err_q      <= 1'b0;
            fail_idx_q <= C_ZERO;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_y_q   <= '0;
            seen_q     <= C_ZERO;
            total_q    <= C_ZERO;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok_d) begin
                        pass_cnt_q <= C_ZERO;
                        fail_cnt_q <= C_ZERO;
                        err_q      <= 1'b0;
                        fail_idx_q <= C_ZERO;
                        fail_a_q   <= '0;
                        fail_b_q   <= '0;
                        fail_y_q   <= '0;
                        seen_q     <= C_ZERO;
                        total_q    <= vec_total;
                        if (vec_total != C_ZERO) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            // Empty run completes immediately with zero counts.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (accept_d) begin
                        if (match_d) begin
                            pass_cnt_q <= pass_inc_d;
                        end else begin
                            fail_cnt_q <= fail_inc_d;
                            err_q      <= 1'b1;
                            // Only the first mismatch of a run is captured.
                            if (!err_q) begin
                                fail_idx_q <= seen_q;
                                fail_a_q   <= a;
                                fail_b_q   <= b;
                                fail_y_q   <= y;
                            end
                        end
                        seen_q <= seen_inc_d;
                        if (last_vec_d) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign err      = err_q;
    assign fail_idx = fail_idx_q;
    assign fail_a   = fail_a_q;
    assign fail_b   = fail_b_q;
    assign fail_y   = fail_y_q;

endmodule
`default_nettype wire
